// File: rtl/sub_share_ctrl_pkg.sv
// Shared types and constants for the shared subtractor controller.
// Holds FSM encoding, datapath width and requester ids.
package sub_share_ctrl_pkg;

  localparam int DATA_W = 64;

  localparam logic REQ0_ID = 1'b0;
  localparam logic REQ1_ID = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic                     id;
  } op_t;

  // High when requester 1 wins; ptr names the favoured requester.
  function automatic logic pick_req1(
    input logic v0,
    input logic v1,
    input logic ptr,
    input logic rr
  );
    return v1 && (!v0 || (rr && ptr));
  endfunction

endpackage

// File: rtl/bit64_sub.sv
// 64-bit two's complement subtractor with signed overflow flag.
// Wraps on overflow; flag marks an out-of-range result.
module bit64_sub
  import sub_share_ctrl_pkg::*;
(
  output logic signed [DATA_W-1:0] diff,
  output logic                     overflow,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b
);

  // Difference and overflow from the operand signs
  always_comb begin
    diff     = a - b;
    overflow = (a[DATA_W-1] != b[DATA_W-1])
            && (diff[DATA_W-1] != a[DATA_W-1]);
  end

endmodule

// File: rtl/sub_share_ctrl.sv
// Two requesters sharing one 64-bit subtractor.
// Arbitrate in IDLE, compute in CALC, present result in HOLD.
module sub_share_ctrl
  import sub_share_ctrl_pkg::*;
#(
  parameter int RR_EN     = 1,
  parameter int OVF_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic signed [DATA_W-1:0] req0_a,
  input  logic signed [DATA_W-1:0] req0_b,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic signed [DATA_W-1:0] req1_a,
  input  logic signed [DATA_W-1:0] req1_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic signed [DATA_W-1:0] rsp_diff,
  output logic                     rsp_overflow,
  output logic                     busy,
  output logic [OVF_CNT_W-1:0]     ovf_count
);

  localparam logic [OVF_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [OVF_CNT_W-1:0] CNT_ONE = OVF_CNT_W'(1);

  state_t                   state;
  logic                     ptr;
  op_t                      op;
  logic signed [DATA_W-1:0] sub_diff;
  logic                     sub_ovf;
  logic                     gnt1;
  logic                     take;

  // Grant decision and combinational readies, only while IDLE
  always_comb begin
    gnt1 = pick_req1(req0_valid, req1_valid, ptr, RR_EN != 0);
    req0_ready = !rst && (state == IDLE)
              && req0_valid && !gnt1;
    req1_ready = !rst && (state == IDLE) && gnt1;
    take = req0_ready || req1_ready;
    busy = (state != IDLE);
  end

  bit64_sub u_sub (
    .diff     (sub_diff),
    .overflow (sub_ovf),
    .a        (op.a),
    .b        (op.b)
  );

  // Controller FSM with registered response and overflow count
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= REQ0_ID;
      op           <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= REQ0_ID;
      rsp_diff     <= '0;
      rsp_overflow <= 1'b0;
      ovf_count    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            op.a  <= gnt1 ? req1_a : req0_a;
            op.b  <= gnt1 ? req1_b : req0_b;
            op.id <= gnt1 ? REQ1_ID : REQ0_ID;
            state <= CALC;
            if (RR_EN != 0) begin
              ptr <= gnt1 ? REQ0_ID : REQ1_ID;
            end
          end
        end
        CALC: begin
          rsp_diff     <= sub_diff;
          rsp_overflow <= sub_ovf;
          rsp_id       <= op.id;
          rsp_valid    <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            if (rsp_overflow && ovf_count != CNT_MAX) begin
              ovf_count <= ovf_count + CNT_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sub_share_ctrl.md
SUB_SHARE_CTRL -- requirements
Module: sub_share_ctrl

Interface
REQ-001 SHALL have parameter RR_EN, default 1, arbitration mode: 1 = round-robin, 0 = fixed priority with req0 highest.
REQ-002 SHALL have parameter OVF_CNT_W, default 8, width of the saturating overflow counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports req0_valid input 1, req0_ready output 1, req0_a input 64 signed, req0_b input 64 signed, forming requester 0's operand channel.
REQ-006 SHALL have ports req1_valid, req1_ready, req1_a and req1_b, identical to REQ-005, forming requester 1's operand channel.
REQ-007 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_id output 1 (the served requester), rsp_diff output 64 signed (a-b), rsp_overflow output 1.
REQ-008 SHALL have port busy, output 1, high whenever the state is not IDLE.
REQ-009 SHALL have port ovf_count, output OVF_CNT_W, the number of delivered responses with overflow, saturating.

Function
REQ-010 SHALL implement FSM states IDLE, CALC and HOLD.
REQ-011 In IDLE: the grant SHALL go to one valid requester; that requester's ready SHALL be asserted combinationally in the same cycle, with the other ready low.
REQ-012 In IDLE: on valid&&ready, a, b and id SHALL be latched into operand registers and the state SHALL move to CALC.
REQ-013 Both readies SHALL be 0 in CALC and HOLD, so no second operation is accepted until the response completes.
REQ-014 In CALC: diff = a - b (64-bit two's complement, wrap) and overflow SHALL be registered into the rsp_* outputs, rsp_valid SHALL be set to 1, and the state SHALL move to HOLD.
REQ-015 Overflow SHALL be 1 iff a[63] != b[63] and diff[63] != a[63].
REQ-016 In HOLD: the rsp_* outputs SHALL stay stable while rsp_ready=0; on rsp_ready=1, rsp_valid SHALL be 0 the next cycle and the state SHALL return to IDLE.
REQ-017 Latency SHALL be: acceptance in cycle N gives rsp_valid=1 in cycle N+2; the minimum issue interval SHALL be 3 cycles.
REQ-018 Round-robin (RR_EN=1): a priority pointer SHALL select the favoured requester; after each grant the pointer SHALL point to the non-granted requester.
REQ-019 A lone valid requester SHALL be granted regardless of the pointer.
REQ-020 Fixed priority (RR_EN=0): req0 SHALL win whenever req0_valid=1; the pointer SHALL be unused.
REQ-021 Neither valid in IDLE: the state, pointer and both readies SHALL be unchanged or low.
REQ-022 A requester dropping valid before its grant SHALL lose nothing, and no operation SHALL be recorded.
REQ-023 ovf_count SHALL increment on each rsp_valid&&rsp_ready&&rsp_overflow handshake and SHALL hold at 2^OVF_CNT_W-1.
REQ-024 When rsp_valid=0, rsp_diff, rsp_overflow and rsp_id SHALL hold their last values.

Reset
REQ-025 On rst=1 at a clock edge: state = IDLE, rsp_valid = 0, rsp_diff = 0, rsp_overflow = 0, rsp_id = 0, pointer = req0, ovf_count = 0, operand registers = 0.
REQ-026 Reset SHALL take precedence over every other event, including a valid handshake in the same cycle.
REQ-027 Reset in CALC or HOLD SHALL discard the pending operation with no response delivered.
REQ-028 Both readies SHALL be 0 while rst=1.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (2-bit IDLE=0, CALC=1, HOLD=2), the DATA_W=64 constant and the requester-id constants.
REQ-030 The datapath SHALL be one instance of the team's 64-bit subtractor bit64_sub (diff, overflow, A, B), fed from the operand registers.
REQ-031 The arbitration logic SHALL stay inline; no further sub-modules SHALL be used.

Verification
REQ-032 Scenario, req0 only: a=22222222222, b=33333333333 -> rsp_id=0, diff=-11111111111, overflow=0, rsp_valid exactly 2 cycles after acceptance.
REQ-033 Scenario, req1 only: a=0x7FFFFFFFFFFFFFFF, b=-1 -> diff=0x8000000000000000, overflow=1, ovf_count 0 -> 1.
REQ-034 Scenario, RR_EN=1 with both valid continuously for 4 ops -> grant order 0,1,0,1; with RR_EN=0 -> order 0,0,0,0.
REQ-035 Scenario, rsp_ready=0 for 5 cycles in HOLD -> rsp_* stable, both readies 0, then a single handshake, then IDLE.
REQ-036 Scenario, rst pulsed in HOLD with a=9999999999999, b=9999 pending -> next cycle rsp_valid=0, state IDLE, ovf_count=0, pointer=req0.
REQ-037 Scenario, 256 overflowing ops with OVF_CNT_W=8 -> ovf_count saturates at 255.
